// File: rtl/worley_point_animator.sv
// rtl/worley_point_animator.sv - per-frame Worley seed point animator with border reflection
// Optional WORLEY_JITTER_EN: LFSR-driven speed reload whenever an axis reflects.
module worley_point_animator #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pause,
  output logic [39:0] pts_x,
  output logic [39:0] pts_y,
  output logic [19:0] frame_count,
  output logic        pts_updated,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_UPD0, S_UPD1, S_UPD2, S_UPD3, S_COMMIT} state_t;

  localparam logic [10:0] X_LIM = 11'(H_DISPLAY);
  localparam logic [10:0] Y_LIM = 11'(V_DISPLAY);
  localparam logic [9:0]  X_RST  [4] = '{10'd100, 10'd300, 10'd500, 10'd100};
  localparam logic [9:0]  Y_RST  [4] = '{10'd100, 10'd200, 10'd400, 10'd380};
  localparam logic [2:0]  SX_RST [4] = '{3'd1, 3'd2, 3'd1, 3'd3};
  localparam logic [2:0]  SY_RST [4] = '{3'd1, 3'd1, 3'd3, 3'd2};

  state_t      r_state;
  logic        r_vsync_q;
  logic [9:0]  r_shx [4];
  logic [9:0]  r_shy [4];
  logic        r_dx  [4];
  logic        r_dy  [4];
  logic [2:0]  w_sx  [4];
  logic [2:0]  w_sy  [4];
  logic [1:0]  w_idx;
  state_t      w_next;
  logic [10:0] w_stx;
  logic [10:0] w_sty;

  // Returns {flip, new_pos}; 11-bit sum keeps pos+speed from wrapping before the compare.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic [2:0] spd,
                                            input logic dir, input logic [10:0] lim);
    logic [10:0] n;
    logic [10:0] last;
    last = lim - 11'd1;
    if (dir) begin
      n = {1'b0, pos} + {8'b0, spd};
      if (n > last) return {1'b1, last[9:0]};
      return {1'b0, n[9:0]};
    end
    if ({1'b0, pos} < {8'b0, spd}) return {1'b1, 10'd0};
    return {1'b0, pos - {7'b0, spd}};
  endfunction

  always_comb begin
    w_idx  = 2'd0;
    w_next = S_IDLE;
    case (r_state)
      S_UPD0: begin w_idx = 2'd0; w_next = S_UPD1;   end
      S_UPD1: begin w_idx = 2'd1; w_next = S_UPD2;   end
      S_UPD2: begin w_idx = 2'd2; w_next = S_UPD3;   end
      S_UPD3: begin w_idx = 2'd3; w_next = S_COMMIT; end
      default: ;
    endcase
  end

  assign w_stx = axis_step(r_shx[w_idx], w_sx[w_idx], r_dx[w_idx], X_LIM);
  assign w_sty = axis_step(r_shy[w_idx], w_sy[w_idx], r_dy[w_idx], Y_LIM);

`ifdef WORLEY_JITTER_EN
  logic [15:0] r_lfsr;
  logic [2:0]  r_sx [4];
  logic [2:0]  r_sy [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
      for (int i = 0; i < 4; i++) begin
        r_sx[i] <= SX_RST[i];
        r_sy[i] <= SY_RST[i];
      end
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (r_state inside {S_UPD0, S_UPD1, S_UPD2, S_UPD3}) begin
        if (w_stx[10]) r_sx[w_idx] <= {1'b0, r_lfsr[1:0]} + 3'd1;
        if (w_sty[10]) r_sy[w_idx] <= {1'b0, r_lfsr[1:0]} + 3'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_sx[i] = r_sx[i];
      w_sy[i] = r_sy[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_sx[i] = SX_RST[i];
      w_sy[i] = SY_RST[i];
    end
  end
`endif

  // Reset also aborts any in-flight update: the shadow snaps back and no strobe is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_vsync_q   <= 1'b0;
      frame_count <= 20'd0;
      pts_updated <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shx[i]          <= X_RST[i];
        r_shy[i]          <= Y_RST[i];
        r_dx[i]           <= 1'b1;
        r_dy[i]           <= 1'b1;
        pts_x[i*10 +: 10] <= X_RST[i];
        pts_y[i*10 +: 10] <= Y_RST[i];
      end
    end else begin
      r_vsync_q   <= vsync;
      pts_updated <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (vsync && !r_vsync_q && !pause) begin
            r_state <= S_UPD0;
            busy    <= 1'b1;
          end
        end
        S_UPD0, S_UPD1, S_UPD2, S_UPD3: begin
          r_shx[w_idx] <= w_stx[9:0];
          r_shy[w_idx] <= w_sty[9:0];
          if (w_stx[10]) r_dx[w_idx] <= ~r_dx[w_idx];
          if (w_sty[10]) r_dy[w_idx] <= ~r_dy[w_idx];
          r_state <= w_next;
        end
        S_COMMIT: begin
          for (int i = 0; i < 4; i++) begin
            pts_x[i*10 +: 10] <= r_shx[i];
            pts_y[i*10 +: 10] <= r_shy[i];
          end
          frame_count <= frame_count + 20'd1;
          pts_updated <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_worley_point_animator.sv
// tb/tb_worley_point_animator.sv - scoreboard bench for worley_point_animator
module tb_worley_point_animator;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        pause;
  logic [39:0] pts_x;
  logic [39:0] pts_y;
  logic [19:0] frame_count;
  logic        pts_updated;
  logic        busy;

  always #5 clk = ~clk;

  worley_point_animator #(.H_DISPLAY(640), .V_DISPLAY(480)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
    .pts_x(pts_x), .pts_y(pts_y), .frame_count(frame_count),
    .pts_updated(pts_updated), .busy(busy)
  );

  typedef struct packed {
    logic [19:0]      fc;
    logic [3:0][9:0]  px;
    logic [3:0][9:0]  py;
    logic [3:0]       mx;
    logic [3:0]       my;
  } exp_t;

  localparam logic [39:0] RST_X = {10'd100, 10'd500, 10'd300, 10'd100};
  localparam logic [39:0] RST_Y = {10'd380, 10'd400, 10'd200, 10'd100};
  localparam logic [39:0] F1_X  = {10'd103, 10'd501, 10'd302, 10'd101};
  localparam logic [39:0] F1_Y  = {10'd382, 10'd403, 10'd201, 10'd101};
  localparam logic [39:0] F2_X  = {10'd106, 10'd502, 10'd304, 10'd102};
  localparam logic [39:0] F2_Y  = {10'd384, 10'd406, 10'd202, 10'd102};

  exp_t q[$];
  exp_t e_mon;
  exp_t e_st;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  int   n_pushed  = 0;
  int   busy_cnt  = 0;
  int   cur_frame = 0;

`ifdef WORLEY_JITTER_EN
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_cap;
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t blank(input int fc);
    exp_t e;
    e = '0;
    e.fc = 20'(fc);
    return e;
  endfunction

  function automatic exp_t full(input int fc, input logic [39:0] x, input logic [39:0] y);
    exp_t e;
    e = blank(fc);
    e.px = x;
    e.py = y;
    e.mx = 4'hF;
    e.my = 4'hF;
    return e;
  endfunction

  task automatic push(input exp_t e);
    q.push_back(e);
    n_pushed++;
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!reset && pts_updated) begin
      n_strobes++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: frame_count=%0d, no update expected", frame_count);
      end else begin
        e_mon = q.pop_front();
        check("frame_count", 64'(frame_count), 64'(e_mon.fc));
        for (int i = 0; i < 4; i++) begin
          if (e_mon.mx[i]) check($sformatf("p%0d.x@f%0d", i, e_mon.fc), 64'(pts_x[i*10 +: 10]), 64'(e_mon.px[i]));
          if (e_mon.my[i]) check($sformatf("p%0d.y@f%0d", i, e_mon.fc), 64'(pts_y[i*10 +: 10]), 64'(e_mon.py[i]));
        end
      end
    end
  end

  task automatic do_frame(input logic p, input int hold);
    @(negedge clk);
    vsync = 1'b1;
    pause = p;
    for (int c = 1; c <= hold + 10; c++) begin
      @(negedge clk);
      if (c == hold) begin
        vsync = 1'b0;
        pause = 1'b0;
      end
`ifdef WORLEY_JITTER_EN
      if (c == 3 && cur_frame == 140) lfsr_cap = lfsr_m;
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vsync = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pts_x", 64'(pts_x), 64'(RST_X));
    check("rst_pts_y", 64'(pts_y), 64'(RST_Y));
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pts_updated", 64'(pts_updated), 64'd0);

    // single frame with cycle-exact strobe timing
    push(full(1, F1_X, F1_Y));
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    check("busy_k", 64'(busy), 64'd1);
    check("strobe_k", 64'(pts_updated), 64'd0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("strobe_k%0d", j), 64'(pts_updated), 64'd0);
      check($sformatf("busy_k%0d", j), 64'(busy), 64'd1);
      check($sformatf("hold_x_k%0d", j), 64'(pts_x), 64'(RST_X));
    end
    @(negedge clk);
    check("strobe_k5", 64'(pts_updated), 64'd1);
    @(negedge clk);
    check("strobe_k6", 64'(pts_updated), 64'd0);
    check("busy_k6", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);

    // paused edge
    busy_cnt = 0;
    do_frame(1'b1, 1);
    check("pause_busy_cycles", 64'(busy_cnt), 64'd0);
    check("pause_frame_count", 64'(frame_count), 64'd1);
    check("pause_pts_x", 64'(pts_x), 64'(F1_X));
    check("pause_pts_y", 64'(pts_y), 64'(F1_Y));

    // reset during UPD1
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_pts_x", 64'(pts_x), 64'(RST_X));
    check("abort_pts_y", 64'(pts_y), 64'(RST_Y));
    check("abort_frame_count", 64'(frame_count), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);

    cur_frame = 1;
    push(full(1, F1_X, F1_Y));
    do_frame(1'b0, 1);
    check("after_abort_fc", 64'(frame_count), 64'd1);

    // vsync held high for two lines: one update only
    cur_frame = 2;
    push(full(2, F2_X, F2_Y));
    do_frame(1'b0, 1600);
    check("held_vsync_fc", 64'(frame_count), 64'd2);

    for (int n = 3; n <= 142; n++) begin
      cur_frame = n;
      e_st = blank(n);
      case (n)
        50:  begin e_st.py[3] = 10'd479; e_st.my[3] = 1'b1; end
`ifndef WORLEY_JITTER_EN
        51:  begin e_st.py[3] = 10'd477; e_st.my[3] = 1'b1; end
        142: begin e_st.px[2] = 10'd637; e_st.mx[2] = 1'b1; end
        141: begin e_st.px[2] = 10'd638; e_st.mx[2] = 1'b1; end
`else
        141: begin e_st.px[2] = 10'd639 - 10'({1'b0, lfsr_cap[1:0]} + 3'd1); e_st.mx[2] = 1'b1; end
`endif
        100: begin
          e_st.px[0] = 10'd200; e_st.py[0] = 10'd200;
          e_st.px[1] = 10'd500; e_st.py[1] = 10'd300;
          e_st.mx[1:0] = 2'b11; e_st.my[1:0] = 2'b11;
        end
        139: begin e_st.px[2] = 10'd639; e_st.mx[2] = 1'b1; end
        140: begin e_st.px[2] = 10'd639; e_st.mx[2] = 1'b1; end
        default: ;
      endcase
      push(e_st);
      do_frame(1'b0, 1);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("strobe_count", 64'(n_strobes), 64'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
